// File: rtl/decode_stage.sv
// RV32/RV64 base-ISA decode stage: field extraction, immediate generation and
// illegal-opcode detection behind a single-entry valid/ready pipeline register.
module decode_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PC_W = XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_insn,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      out_opcode,
  output logic [3:0]      out_alu_op,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic            out_rd_we,
  output logic            out_invalid
);

  localparam logic [4:0] OPC_LOAD      = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM  = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM    = 5'b00100;
  localparam logic [4:0] OPC_AUIPC     = 5'b00101;
  localparam logic [4:0] OPC_OP_IMM_32 = 5'b00110;
  localparam logic [4:0] OPC_STORE     = 5'b01000;
  localparam logic [4:0] OPC_OP        = 5'b01100;
  localparam logic [4:0] OPC_LUI       = 5'b01101;
  localparam logic [4:0] OPC_OP_32     = 5'b01110;
  localparam logic [4:0] OPC_BRANCH    = 5'b11000;
  localparam logic [4:0] OPC_JALR      = 5'b11001;
  localparam logic [4:0] OPC_JAL       = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM    = 5'b11100;
  localparam logic [2:0] F3_SR         = 3'b101;
  localparam bit         RV64          = (XLEN == 64);

  logic [4:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [4:0]      w_rd;
  logic            w_legal;
  logic            w_alt;
  logic            w_no_wr;
  logic [31:0]     w_imm32;
  logic            w_invalid;
  logic [XLEN-1:0] w_imm;
  logic [3:0]      w_alu_op;
  logic            w_rd_we;
  logic            w_accept;

  logic            r_valid;
  logic [PC_W-1:0] r_pc;
  logic [4:0]      r_opcode;
  logic [3:0]      r_alu_op;
  logic [4:0]      r_rd;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [XLEN-1:0] r_imm;
  logic            r_rd_we;
  logic            r_invalid;

  assign w_opcode = in_insn[6:2];
  assign w_funct3 = in_insn[14:12];
  assign w_rd     = in_insn[11:7];

  // Per-opcode legality, immediate format, ALU-op extension and rd-write suppression.
  always_comb begin
    w_legal = 1'b0;
    w_alt   = 1'b0;
    w_no_wr = 1'b0;
    w_imm32 = '0;
    case (w_opcode)
      OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
        w_legal = 1'b1;
        w_imm32 = {{20{in_insn[31]}}, in_insn[31:20]};
      end
      OPC_OP_IMM: begin
        w_legal = 1'b1;
        w_alt   = (w_funct3 == F3_SR);
        w_imm32 = {{20{in_insn[31]}}, in_insn[31:20]};
      end
      OPC_OP_IMM_32: begin
        w_legal = RV64;
        w_alt   = (w_funct3 == F3_SR);
        w_imm32 = {{20{in_insn[31]}}, in_insn[31:20]};
      end
      OPC_AUIPC, OPC_LUI: begin
        w_legal = 1'b1;
        w_imm32 = {in_insn[31:12], 12'b0};
      end
      OPC_STORE: begin
        w_legal = 1'b1;
        w_no_wr = 1'b1;
        w_imm32 = {{20{in_insn[31]}}, in_insn[31:25], in_insn[11:7]};
      end
      OPC_BRANCH: begin
        w_legal = 1'b1;
        w_no_wr = 1'b1;
        w_imm32 = {{19{in_insn[31]}}, in_insn[31], in_insn[7], in_insn[30:25],
                   in_insn[11:8], 1'b0};
      end
      OPC_MISC_MEM: begin
        w_legal = 1'b1;
        w_no_wr = 1'b1;
      end
      OPC_OP: begin
        w_legal = 1'b1;
        w_alt   = 1'b1;
      end
      OPC_OP_32: begin
        w_legal = RV64;
        w_alt   = RV64;
      end
      OPC_JAL: begin
        w_legal = 1'b1;
        w_imm32 = {{11{in_insn[31]}}, in_insn[31], in_insn[19:12], in_insn[20],
                   in_insn[30:21], 1'b0};
      end
      default: begin
        w_legal = 1'b0;
      end
    endcase
  end

  // Immediate is zeroed for illegal encodings; the 32-bit form sign-extends to XLEN.
  assign w_invalid = (in_insn[1:0] != 2'b11) || !w_legal;
  assign w_imm     = w_invalid ? '0 : XLEN'($signed(w_imm32));
  assign w_alu_op  = {w_alt & in_insn[30], w_funct3};
  assign w_rd_we   = !w_invalid && !w_no_wr && (w_rd != 5'd0);

  assign in_ready  = !r_valid || out_ready;
  assign w_accept  = in_valid && in_ready;

  // Single-entry pipeline register; flush kills both held and incoming bundles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_opcode  <= '0;
      r_alu_op  <= '0;
      r_rd      <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_imm     <= '0;
      r_rd_we   <= 1'b0;
      r_invalid <= 1'b0;
    end else if (flush) begin
      r_valid   <= 1'b0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_pc      <= in_pc;
      r_opcode  <= w_opcode;
      r_alu_op  <= w_alu_op;
      r_rd      <= w_rd;
      r_rs1     <= in_insn[19:15];
      r_rs2     <= in_insn[24:20];
      r_imm     <= w_imm;
      r_rd_we   <= w_rd_we;
      r_invalid <= w_invalid;
    end else if (out_ready) begin
      r_valid   <= 1'b0;
    end
  end

  assign out_valid   = r_valid;
  assign out_pc      = r_pc;
  assign out_opcode  = r_opcode;
  assign out_alu_op  = r_alu_op;
  assign out_rd      = r_rd;
  assign out_rs1     = r_rs1;
  assign out_rs2     = r_rs2;
  assign out_imm     = r_imm;
  assign out_rd_we   = r_rd_we;
  assign out_invalid = r_invalid;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed instructions on an RV32 instance,
// plus a few RV64-only encodings on a second instance.
module tb_decode_stage;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  opcode;
    logic [3:0]  alu;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        we;
    logic        inv;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_insn, in_pc, out_pc, out_imm;
  logic [4:0]  out_opcode, out_rd, out_rs1, out_rs2;
  logic [3:0]  out_alu_op;
  logic        out_rd_we, out_invalid;

  logic        v64_in_valid, v64_in_ready, v64_out_valid;
  logic [31:0] v64_in_insn;
  logic [63:0] v64_in_pc, v64_out_pc, v64_out_imm;
  logic [4:0]  v64_opcode, v64_rd, v64_rs1, v64_rs2;
  logic [3:0]  v64_alu_op;
  logic        v64_rd_we, v64_invalid;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_insn(in_insn), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_opcode(out_opcode),
    .out_alu_op(out_alu_op), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_imm(out_imm), .out_rd_we(out_rd_we), .out_invalid(out_invalid)
  );

  decode_stage #(.XLEN(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(v64_in_valid), .in_ready(v64_in_ready),
    .in_insn(v64_in_insn), .in_pc(v64_in_pc), .flush(1'b0), .out_valid(v64_out_valid),
    .out_ready(1'b1), .out_pc(v64_out_pc), .out_opcode(v64_opcode),
    .out_alu_op(v64_alu_op), .out_rd(v64_rd), .out_rs1(v64_rs1), .out_rs2(v64_rs2),
    .out_imm(v64_out_imm), .out_rd_we(v64_rd_we), .out_invalid(v64_invalid)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [4:0] opc, input logic [3:0] alu,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] imm, input logic we, input logic inv);
    exp_t e;
    e.pc = pc; e.opcode = opc; e.alu = alu; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
    e.imm = imm; e.we = we; e.inv = inv;
    return e;
  endfunction

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic send(input logic [31:0] insn, input logic [31:0] pc, input exp_t e,
                      input bit push, output int waited);
    in_valid = 1'b1;
    in_insn  = insn;
    in_pc    = pc;
    waited   = 0;
    #1;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: pc 0x%0h never accepted", pc);
    end else if (push) begin
      sb.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Monitor: every consumed bundle must match the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n === 1'b1 && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_bundle: got pc 0x%0h, expected no output", out_pc);
        end else begin
          e = sb.pop_front();
          chk("pc", 64'(out_pc), 64'(e.pc));
          chk("opcode", 64'(out_opcode), 64'(e.opcode));
          chk("alu_op", 64'(out_alu_op), 64'(e.alu));
          chk("rd", 64'(out_rd), 64'(e.rd));
          chk("rs1", 64'(out_rs1), 64'(e.rs1));
          chk("rs2", 64'(out_rs2), 64'(e.rs2));
          chk("imm", 64'(out_imm), 64'(e.imm));
          chk("rd_we", 64'(out_rd_we), 64'(e.we));
          chk("invalid", 64'(out_invalid), 64'(e.inv));
        end
      end
    end
  end

  initial begin
    int w;
    rst_n = 1'b0; in_valid = 1'b1; in_insn = 32'hFFF00093; in_pc = 32'h100;
    flush = 1'b0; out_ready = 1'b1;
    v64_in_valid = 1'b0; v64_in_insn = '0; v64_in_pc = '0;

    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_out_opcode", 64'(out_opcode), 64'd0);
    chk("rst_out_imm", 64'(out_imm), 64'd0);
    chk("rst_out_rd_we", 64'(out_rd_we), 64'd0);
    rst_n = 1'b1; in_valid = 1'b0;
    #1 chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    send(32'hFFF00093, 32'h1000, mk(32'h1000, 5'b00100, 4'b0000, 5'd1, 5'd0, 5'd31, 32'hFFFFFFFF, 1'b1, 1'b0), 1'b1, w);
    chk("addi_latency_valid", 64'(out_valid), 64'd1);

    // Mixed stream at full throughput: each one accepted without waiting.
    send(32'h402081B3, 32'h1004, mk(32'h1004, 5'b01100, 4'b1000, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1, 1'b0), 1'b1, w);
    chk("sub_wait", 64'(w), 64'd0);
    send(32'h0020A423, 32'h1008, mk(32'h1008, 5'b01000, 4'b0010, 5'd8, 5'd1, 5'd2, 32'h8, 1'b0, 1'b0), 1'b1, w);
    chk("sw_wait", 64'(w), 64'd0);
    send(32'hFE000EE3, 32'h100C, mk(32'h100C, 5'b11000, 4'b0000, 5'd29, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b0, 1'b0), 1'b1, w);
    send(32'h4032D293, 32'h1010, mk(32'h1010, 5'b00100, 4'b1101, 5'd5, 5'd5, 5'd3, 32'h403, 1'b1, 1'b0), 1'b1, w);
    send(32'h123452B7, 32'h1014, mk(32'h1014, 5'b01101, 4'b0101, 5'd5, 5'd8, 5'd3, 32'h12345000, 1'b1, 1'b0), 1'b1, w);
    send(32'h00000001, 32'h1018, mk(32'h1018, 5'b00000, 4'b0000, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1), 1'b1, w);
    send(32'h0000007F, 32'h101C, mk(32'h101C, 5'b11111, 4'b0000, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1), 1'b1, w);
    send(32'hFFF0809B, 32'h1020, mk(32'h1020, 5'b00110, 4'b0000, 5'd1, 5'd1, 5'd31, 32'h0, 1'b0, 1'b1), 1'b1, w);
    chk("addiw32_wait", 64'(w), 64'd0);
    repeat (2) @(negedge clk);

    // Backpressure: first bundle must hold for three stalled cycles.
    out_ready = 1'b0;
    fork
      begin
        send(32'hFFF00093, 32'h2000, mk(32'h2000, 5'b00100, 4'b0000, 5'd1, 5'd0, 5'd31, 32'hFFFFFFFF, 1'b1, 1'b0), 1'b1, w);
        send(32'h402081B3, 32'h2004, mk(32'h2004, 5'b01100, 4'b1000, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1, 1'b0), 1'b1, w);
        send(32'h0020A423, 32'h2008, mk(32'h2008, 5'b01000, 4'b0010, 5'd8, 5'd1, 5'd2, 32'h8, 1'b0, 1'b0), 1'b1, w);
      end
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          #2;
          chk("stall_valid", 64'(out_valid), 64'd1);
          chk("stall_in_ready", 64'(in_ready), 64'd0);
          chk("stall_pc", 64'(out_pc), 64'h2000);
          chk("stall_imm", 64'(out_imm), 64'hFFFFFFFF);
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    repeat (3) @(negedge clk);
    chk("bp_drained", 64'(sb.size()), 64'd0);

    // Flush while a stalled bundle is held and a new instruction is offered.
    out_ready = 1'b0;
    send(32'h00100113, 32'h3000, mk(32'h0, 5'd0, 4'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0), 1'b0, w);
    chk("pre_flush_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b1; in_insn = 32'h00200193; in_pc = 32'h3004; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1 chk("flush_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("flush_no_output", 64'(out_valid), 64'd0);

    // RV64 instance: ADDIW and SUBW are legal.
    v64_in_valid = 1'b1; v64_in_insn = 32'hFFF0809B; v64_in_pc = 64'h8000_0000_0000_0000;
    #1 chk("v64_in_ready", 64'(v64_in_ready), 64'd1);
    @(negedge clk);
    v64_in_insn = 32'h402081BB; v64_in_pc = 64'h8000_0000_0000_0004;
    chk("addiw_valid", 64'(v64_out_valid), 64'd1);
    chk("addiw_pc", v64_out_pc, 64'h8000_0000_0000_0000);
    chk("addiw_opcode", 64'(v64_opcode), 64'b00110);
    chk("addiw_imm", v64_out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addiw_invalid", 64'(v64_invalid), 64'd0);
    chk("addiw_rd_we", 64'(v64_rd_we), 64'd1);
    chk("addiw_fields", {44'd0, v64_alu_op, v64_rd, v64_rs1, v64_rs2}, {44'd0, 4'b0000, 5'd1, 5'd1, 5'd31});
    @(negedge clk);
    v64_in_valid = 1'b0;
    chk("subw_valid", 64'(v64_out_valid), 64'd1);
    chk("subw_alu_op", 64'(v64_alu_op), 64'b1000);
    chk("subw_opcode", 64'(v64_opcode), 64'b01110);
    chk("subw_imm", v64_out_imm, 64'd0);
    chk("subw_invalid", 64'(v64_invalid), 64'd0);
    @(negedge clk);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
